// File: rtl/expr_eval_if.sv
// Character stream in, expression result out, for expr_eval_ctrl.
// master = character source / result consumer side, slave = evaluator side.
interface expr_eval_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_data, res_err, res_valid, busy
  );

  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_data, res_err, res_valid, busy
  );
endinterface

// File: rtl/expr_eval_ctrl.sv
// Streaming recognizer/evaluator for ASCII "num (op num)* =" expressions, one result per '='.
// Optional feature macro EXPR_MUL_EN: '*' becomes a multiply with precedence over +/-.
module expr_eval_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      clr,
  expr_eval_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NUM  = 3'd1,
    S_OP   = 3'd2,
    S_ERR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_DIG   = 3'd0,
    C_ADD   = 3'd1,
    C_SUB   = 3'd2,
    C_MUL   = 3'd3,
    C_EQ    = 3'd4,
    C_OTHER = 3'd5
  } cls_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic cls_t classify(input logic [7:0] ch);
    cls_t c;
    if ((ch >= 8'h30) && (ch <= 8'h39)) c = C_DIG;
    else if (ch == 8'h2B)               c = C_ADD;
    else if (ch == 8'h2D)               c = C_SUB;
`ifdef EXPR_MUL_EN
    else if (ch == 8'h2A)               c = C_MUL;
`endif
    else if (ch == 8'h3D)               c = C_EQ;
    else                                c = C_OTHER;
    return c;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_r, acc_nxt_s;
  logic [WIDTH-1:0] num_r, num_nxt_s;
  logic             sgn_r, sgn_nxt_s;
  logic [WIDTH-1:0] res_data_r, res_data_nxt_s;
  logic             res_err_r, res_err_nxt_s;
  logic             res_valid_r, in_ready_r, busy_r;

  logic             accept_s;
  cls_t             cls_s;
  logic [WIDTH-1:0] digit_s, num10_s, prod_s, eval_s;

  assign accept_s = io.in_valid && in_ready_r;
  assign cls_s    = classify(io.in_data);
  assign digit_s  = {{(WIDTH-4){1'b0}}, io.in_data[3:0]};
  assign num10_s  = (num_r << 3'd3) + (num_r << 3'd1) + digit_s;

`ifdef EXPR_MUL_EN
  logic [WIDTH-1:0] term_r, term_nxt_s;
  assign prod_s = term_r * num_r;
`else
  assign prod_s = num_r;
`endif

  // Pending term folded into the accumulator with the sign of the operator that preceded it
  assign eval_s = sgn_r ? (acc_r - prod_s) : (acc_r + prod_s);

  // Next-state and datapath update; only an accepted character advances, S_DONE waits on res_ready
  always_comb begin
    state_nxt_s    = state_r;
    acc_nxt_s      = acc_r;
    num_nxt_s      = num_r;
    sgn_nxt_s      = sgn_r;
    res_data_nxt_s = res_data_r;
    res_err_nxt_s  = res_err_r;
`ifdef EXPR_MUL_EN
    term_nxt_s     = term_r;
`endif
    if (state_r == S_DONE) begin
      if (io.res_ready) begin
        state_nxt_s = S_IDLE;
        acc_nxt_s   = '0;
        num_nxt_s   = '0;
        sgn_nxt_s   = 1'b0;
`ifdef EXPR_MUL_EN
        term_nxt_s  = ONE;
`endif
      end else begin
        state_nxt_s = S_DONE;
      end
    end else if (accept_s) begin
      case (state_r)
        S_IDLE, S_OP: begin
          case (cls_s)
            C_DIG: begin
              state_nxt_s = S_NUM;
              num_nxt_s   = digit_s;
            end
            C_EQ: begin
              state_nxt_s    = S_DONE;
              res_data_nxt_s = '0;
              res_err_nxt_s  = 1'b1;
            end
            default: state_nxt_s = S_ERR;
          endcase
        end
        S_NUM: begin
          case (cls_s)
            C_DIG: num_nxt_s = num10_s;
            C_ADD, C_SUB: begin
              state_nxt_s = S_OP;
              acc_nxt_s   = eval_s;
              num_nxt_s   = '0;
              sgn_nxt_s   = (cls_s == C_SUB);
`ifdef EXPR_MUL_EN
              term_nxt_s  = ONE;
`endif
            end
`ifdef EXPR_MUL_EN
            C_MUL: begin
              state_nxt_s = S_OP;
              term_nxt_s  = prod_s;
              num_nxt_s   = '0;
            end
`endif
            C_EQ: begin
              state_nxt_s    = S_DONE;
              acc_nxt_s      = eval_s;
              res_data_nxt_s = eval_s;
              res_err_nxt_s  = 1'b0;
            end
            default: state_nxt_s = S_ERR;
          endcase
        end
        S_ERR: begin
          if (cls_s == C_EQ) begin
            state_nxt_s    = S_DONE;
            res_data_nxt_s = '0;
            res_err_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = S_ERR;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, datapath and registered handshake outputs derived from the next state
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= S_IDLE;
      acc_r       <= '0;
      num_r       <= '0;
      sgn_r       <= 1'b0;
      res_data_r  <= '0;
      res_err_r   <= 1'b0;
      res_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
`ifdef EXPR_MUL_EN
      term_r      <= ONE;
`endif
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      num_r       <= num_nxt_s;
      sgn_r       <= sgn_nxt_s;
      res_data_r  <= res_data_nxt_s;
      res_err_r   <= res_err_nxt_s;
      res_valid_r <= (state_nxt_s == S_DONE);
      in_ready_r  <= (state_nxt_s != S_DONE);
      busy_r      <= (state_nxt_s == S_NUM) || (state_nxt_s == S_OP) || (state_nxt_s == S_ERR);
`ifdef EXPR_MUL_EN
      term_r      <= term_nxt_s;
`endif
    end
  end

  assign io.in_ready  = in_ready_r;
  assign io.res_data  = res_data_r;
  assign io.res_err   = res_err_r;
  assign io.res_valid = res_valid_r;
  assign io.busy      = busy_r;

endmodule
